// File: rtl/jtframe_nvram_ioctl.sv
// Arbitrates the 8-bit NVRAM port 1B between the game CPU and the framework
// ioctl load/dump channel. It drives the port select and tracks a dirty flag.
module jtframe_nvram_ioctl #(
  parameter int AW   = 10,
  parameter int LAST = 2**(AW+1)-1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_cs,
  input  logic          cpu_we,
  input  logic [AW:0]   cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_ok,
  input  logic          ioctl_ram,
  input  logic [AW:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          ioctl_wr,
  input  logic          ioctl_rd,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_din_ok,
  output logic          nv_sel_b,
  output logic [AW:0]   nv_addr,
  output logic [7:0]    nv_data,
  output logic          nv_we,
  input  logic [7:0]    nv_q,
  output logic          dirty,
  output logic [2:0]    fsm_state
);

  typedef enum logic [2:0] {IDLE, WR, RD0, RD1, DONE} state_t;

  localparam logic [AW:0] LAST_A = LAST[AW:0];

  state_t      state;
  logic        src_io;
  logic        pend_vld;
  logic        pend_wr;
  logic [AW:0] pend_addr;
  logic [7:0]  pend_data;
  logic        strobe;
  logic        io_req;
  logic        io_wr;
  logic [AW:0] io_addr;
  logic [7:0]  io_data;

  assign fsm_state = state;
  assign strobe    = ioctl_ram & (ioctl_wr | ioctl_rd);

  // A live strobe wins over the pending one; it is the newer request.
  always_comb begin
    io_req  = 1'b0;
    io_wr   = 1'b0;
    io_addr = pend_addr;
    io_data = pend_data;
    if (strobe) begin
      io_req  = 1'b1;
      io_wr   = ioctl_wr;
      io_addr = ioctl_addr;
      io_data = ioctl_dout;
    end else if (pend_vld && ioctl_ram) begin
      io_req  = 1'b1;
      io_wr   = pend_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      src_io       <= 1'b0;
      pend_vld     <= 1'b0;
      pend_wr      <= 1'b0;
      pend_addr    <= '0;
      pend_data    <= '0;
      cpu_ok       <= 1'b0;
      ioctl_din_ok <= 1'b0;
      nv_we        <= 1'b0;
      nv_sel_b     <= 1'b0;
      dirty        <= 1'b0;
      cpu_dout     <= '0;
      ioctl_din    <= '0;
      nv_addr      <= '0;
      nv_data      <= '0;
    end else begin
      cpu_ok       <= 1'b0;
      ioctl_din_ok <= 1'b0;
      // Pending strobes only survive while the framework owns the RAM.
      if (!ioctl_ram) begin
        pend_vld <= 1'b0;
      end else if (strobe && state != IDLE) begin
        pend_vld  <= 1'b1;
        pend_wr   <= ioctl_wr;
        pend_addr <= ioctl_addr;
        pend_data <= ioctl_dout;
      end
      case (state)
        IDLE: begin
          if (io_req) begin
            pend_vld <= 1'b0;
            src_io   <= 1'b1;
            nv_sel_b <= 1'b1;
            nv_addr  <= io_addr;
            if (io_wr) begin
              nv_we   <= 1'b1;
              nv_data <= io_data;
              dirty   <= 1'b0;
              state   <= WR;
            end else begin
              state   <= RD0;
            end
          end else if (cpu_cs && !ioctl_ram) begin
            src_io   <= 1'b0;
            nv_sel_b <= 1'b1;
            nv_addr  <= cpu_addr;
            if (cpu_we) begin
              nv_we   <= 1'b1;
              nv_data <= cpu_din;
              dirty   <= 1'b1;
              state   <= WR;
            end else begin
              state   <= RD0;
            end
          end
        end
        WR: begin
          nv_we    <= 1'b0;
          nv_sel_b <= 1'b0;
          cpu_ok   <= !src_io;
          state    <= DONE;
        end
        RD0: state <= RD1;
        RD1: begin
          nv_sel_b <= 1'b0;
          if (src_io) begin
            ioctl_din    <= nv_q;
            ioctl_din_ok <= 1'b1;
            if (nv_addr == LAST_A) dirty <= 1'b0;
          end else begin
            cpu_dout <= nv_q;
            cpu_ok   <= 1'b1;
          end
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_nvram_ioctl.sv
// Directed bench for jtframe_nvram_ioctl with AW=2 (LAST=7) and a
// registered one-cycle-latency memory model on port 1B.
module tb_jtframe_nvram_ioctl;
  localparam int AW   = 2;
  localparam int LAST = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_cs = 1'b0, cpu_we = 1'b0;
  logic [AW:0]   cpu_addr = '0;
  logic [7:0]    cpu_din = '0;
  logic [7:0]    cpu_dout;
  logic          cpu_ok;
  logic          ioctl_ram = 1'b0;
  logic [AW:0]   ioctl_addr = '0;
  logic [7:0]    ioctl_dout = '0;
  logic          ioctl_wr = 1'b0, ioctl_rd = 1'b0;
  logic [7:0]    ioctl_din;
  logic          ioctl_din_ok;
  logic          nv_sel_b;
  logic [AW:0]   nv_addr;
  logic [7:0]    nv_data;
  logic          nv_we;
  logic [7:0]    nv_q;
  logic          dirty;
  logic [2:0]    fsm_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  jtframe_nvram_ioctl #(.AW(AW), .LAST(LAST)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ok(cpu_ok),
    .ioctl_ram(ioctl_ram), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd),
    .ioctl_din(ioctl_din), .ioctl_din_ok(ioctl_din_ok),
    .nv_sel_b(nv_sel_b), .nv_addr(nv_addr), .nv_data(nv_data), .nv_we(nv_we),
    .nv_q(nv_q), .dirty(dirty), .fsm_state(fsm_state)
  );

  // ---------------- memory model and event monitor ----------------
  logic [7:0] mem [0:7];
  logic       preload = 1'b0;
  int         we_cnt = 0, ok_cnt = 0, din_ok_cnt = 0, stray_we = 0;
  logic [AW:0] last_wa = '0;
  logic [7:0]  last_wd = '0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h10 + 8'(i);
    end else if (nv_we) begin
      mem[nv_addr] <= nv_data;
    end
    nv_q <= mem[nv_addr];
  end

  always @(posedge clk) begin
    if (nv_we) begin
      we_cnt++;
      last_wa = nv_addr;
      last_wd = nv_data;
      if (!nv_sel_b) stray_we++;
    end
    if (cpu_ok) ok_cnt++;
    if (ioctl_din_ok) din_ok_cnt++;
  end

  // ---------------- scoreboard ----------------
  int tests = 0, fails = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic wait_for(input logic is_din, input int start, output int lat);
    lat = start;
    for (int i = 0; i < 12; i++) begin
      if (is_din ? ioctl_din_ok : cpu_ok) return;
      @(negedge clk);
      lat++;
    end
    lat = -1;
  endtask

  task automatic cpu_access(input logic we, input logic [AW:0] a, input logic [7:0] d,
                            output int lat);
    cpu_cs = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
    wait_for(1'b0, 0, lat);
    cpu_cs = 1'b0;
    @(negedge clk);
  endtask

  task automatic io_strobe(input logic wr, input logic [AW:0] a, input logic [7:0] d);
    ioctl_wr = wr; ioctl_rd = !wr; ioctl_addr = a; ioctl_dout = d;
    @(negedge clk);
    ioctl_wr = 1'b0; ioctl_rd = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [AW:0] addr;
    logic [7:0]  din;
    logic [7:0]  exp_dout;
    int          exp_lat;
    logic        exp_dirty;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat, w0, ok0, d0;
    vecs[0] = '{1'b1, 3'd3, 8'h5A, 8'h00, 2, 1'b1};
    vecs[1] = '{1'b0, 3'd3, 8'h00, 8'h5A, 3, 1'b1};
    vecs[2] = '{1'b1, 3'd0, 8'hC3, 8'h00, 2, 1'b1};
    vecs[3] = '{1'b0, 3'd0, 8'h00, 8'hC3, 3, 1'b1};
    vecs[4] = '{1'b1, 3'd7, 8'h99, 8'h00, 2, 1'b1};
    vecs[5] = '{1'b0, 3'd7, 8'h00, 8'h99, 3, 1'b1};
    vecs[6] = '{1'b0, 3'd3, 8'h00, 8'h5A, 3, 1'b1};

    // Reset held: requests are ignored and every output stays 0.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("reset_outs", {cpu_ok, ioctl_din_ok, nv_we, nv_sel_b, dirty, cpu_dout,
                           ioctl_din, nv_addr, nv_data, fsm_state}, '0);
      cpu_cs = i[0]; cpu_we = 1'b1; ioctl_ram = 1'b1; ioctl_wr = i[0]; ioctl_rd = i[1];
    end
    check("reset_no_we", we_cnt, 0);
    cpu_cs = 1'b0; ioctl_ram = 1'b0; ioctl_wr = 1'b0; ioctl_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // CPU write/read vectors.
    for (int i = 0; i < 7; i++) begin
      w0 = we_cnt;
      cpu_access(vecs[i].we, vecs[i].addr, vecs[i].din, lat);
      check("cpu_lat", lat, vecs[i].exp_lat);
      if (vecs[i].we) begin
        check("cpu_we_once", we_cnt - w0, 1);
        check("cpu_wr_addr", last_wa, vecs[i].addr);
        check("cpu_wr_data", last_wd, vecs[i].din);
      end else begin
        check("cpu_rd_data", cpu_dout, vecs[i].exp_dout);
        check("cpu_rd_no_we", we_cnt - w0, 0);
      end
      check("cpu_dirty", dirty, vecs[i].exp_dirty);
    end

    // Load: one write, no dump pulse, dirty cleared.
    ioctl_ram = 1'b1;
    w0 = we_cnt; d0 = din_ok_cnt;
    @(negedge clk);
    io_strobe(1'b1, 3'd6, 8'hA5);
    repeat (4) @(negedge clk);
    check("load_we_once", we_cnt - w0, 1);
    check("load_addr", last_wa, 3'd6);
    check("load_data", last_wd, 8'hA5);
    check("load_dirty", dirty, 1'b0);
    check("load_no_din_ok", din_ok_cnt - d0, 0);

    // Dump of the whole image; dirty must survive until address LAST.
    ioctl_ram = 1'b0;
    cpu_access(1'b1, 3'd1, 8'h77, lat);
    check("pre_dump_dirty", dirty, 1'b1);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    ioctl_ram = 1'b1;
    d0 = din_ok_cnt;
    @(negedge clk);
    for (int a = 0; a <= LAST; a++) begin
      exp_q.push_back(8'h10 + 8'(a));
      io_strobe(1'b0, 3'(a), 8'h00);
      wait_for(1'b1, 1, lat);
      check("dump_lat", lat, 3);
      check("dump_data", ioctl_din, exp_q.pop_front());
      check("dump_dirty", dirty, (a == LAST) ? 1'b0 : 1'b1);
      repeat (2) @(negedge clk);
    end
    check("dump_pulses", din_ok_cnt - d0, LAST + 1);

    // Contention: ioctl write arrives while a CPU read is in flight.
    ioctl_ram = 1'b0;
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd2;
    w0 = we_cnt;
    @(negedge clk);
    ioctl_ram = 1'b1; ioctl_wr = 1'b1; ioctl_addr = 3'd5; ioctl_dout = 8'h3C;
    @(negedge clk);
    ioctl_wr = 1'b0;
    wait_for(1'b0, 2, lat);
    check("cont_cpu_lat", lat, 3);
    check("cont_cpu_data", cpu_dout, 8'h12);
    check("cont_cpu_first", we_cnt - w0, 0);
    cpu_cs = 1'b0;
    for (int i = 0; i < 10 && we_cnt == w0; i++) @(negedge clk);
    @(negedge clk);
    check("cont_pend_we", we_cnt - w0, 1);
    check("cont_pend_addr", last_wa, 3'd5);
    check("cont_pend_data", last_wd, 8'h3C);

    // Lockout: CPU stalls until ioctl_ram falls.
    repeat (2) @(negedge clk);
    ok0 = ok_cnt;
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 3'd0; cpu_din = 8'hEE;
    repeat (8) @(negedge clk);
    check("lockout_no_ok", ok_cnt - ok0, 0);
    check("lockout_dirty", dirty, 1'b0);
    ioctl_ram = 1'b0;
    wait_for(1'b0, 0, lat);
    check("lockout_release_lat", lat, 2);
    check("lockout_dirty_set", dirty, 1'b1);
    cpu_cs = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset while in WR.
    w0 = we_cnt;
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 3'd4; cpu_din = 8'h55;
    @(negedge clk);
    check("rst_wr_we_high", nv_we, 1'b1);
    check("rst_wr_state", fsm_state, 3'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_we", nv_we, 1'b0);
    check("rst_async_state", fsm_state, 3'd0);
    check("rst_async_sel", nv_sel_b, 1'b0);
    cpu_cs = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_no_write", we_cnt - w0, 0);
    check("rst_mem_intact", mem[4], 8'h14);
    check("rst_dirty", dirty, 1'b0);
    check("we_outside_sel", stray_we, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtframe_nvram_ioctl.md
Name: jtframe_nvram_ioctl

Overview:
- Arbiter and sequencer for the 8-bit read/write port (port 1B) of the dual 16-bit NVRAM.
- Shares that port between the game CPU and the framework ioctl channel, which loads NVRAM from the SD card and dumps it back.
- Owns the port-select line so the port is never driven by two masters at once.
- Keeps a dirty flag that tells the framework when a save is needed.

Parameters:
- AW, 10, word address width of the NVRAM; byte addresses are AW+1 bits wide.
- LAST, 2**(AW+1)-1, byte address that ends a full dump and clears the dirty flag.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- cpu_cs  in  1  CPU access request, held until cpu_ok
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  AW+1  CPU byte address
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  CPU read data, valid when cpu_ok
- cpu_ok  out  1  access complete, one-cycle pulse
- ioctl_ram  in  1  high while the framework owns NVRAM (load or dump)
- ioctl_addr  in  AW+1  byte address from the framework
- ioctl_dout  in  8  load data from the framework
- ioctl_wr  in  1  one-cycle load strobe
- ioctl_rd  in  1  one-cycle dump read strobe
- ioctl_din  out  8  dump data to the framework
- ioctl_din_ok  out  1  dump data valid, one-cycle pulse
- nv_sel_b  out  1  selects port 1B as NVRAM address source
- nv_addr  out  AW+1  port 1B byte address
- nv_data  out  8  port 1B write data
- nv_we  out  1  port 1B write enable
- nv_q  in  8  port 1B read data; registered, valid 1 clk after address
- dirty  out  1  a CPU write has occurred since the last full dump

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - cpu_ok, ioctl_din_ok, nv_we, nv_sel_b, dirty are 0.
  - cpu_dout, ioctl_din, nv_addr, nv_data are 0.
- States and transitions:
  - IDLE: the highest-priority pending request is accepted on a rising edge.
  - WR (1 clk): nv_sel_b=1, nv_we=1, nv_addr/nv_data latched from the source. Then DONE.
  - RD0 (1 clk): nv_sel_b=1, nv_we=0, nv_addr latched.
  - RD1 (1 clk): nv_q is sampled into cpu_dout or ioctl_din. Then DONE.
  - DONE (1 clk): pulse cpu_ok or ioctl_din_ok; for ioctl writes no pulse is issued. nv_sel_b=0. Return to IDLE.
- Latency from acceptance:
  - Write: completion pulse 2 clk after acceptance.
  - Read: data and ok 3 clk after acceptance.
  - A back-to-back request is accepted in the cycle after DONE.
- Arbitration priority: ioctl_wr > ioctl_rd > cpu_cs.
  - ioctl strobes are one-cycle; an ioctl strobe arriving while not in IDLE is latched in a one-deep pending register.
  - A second ioctl strobe arriving while one is already pending overwrites the pending one. The framework spaces strobes by at least 5 clk, so this is out of spec.
- CPU lockout:
  - While ioctl_ram=1, CPU requests are not accepted. cpu_ok stays 0 and the CPU stalls.
  - A CPU access already in flight completes normally.
  - A CPU access pending when ioctl_ram falls is served in the next IDLE cycle.
- ioctl_wr/ioctl_rd with ioctl_ram=0 are ignored.
- nv_we is only ever 1 in WR. nv_sel_b is 1 only in WR/RD0/RD1.
- Dirty flag:
  - Set in the cycle a CPU write passes through WR.
  - Cleared in the DONE of an ioctl read whose address is LAST.
  - ioctl loads clear dirty at their WR; the loaded image equals stored state.
  - A CPU write and a clear in the same cycle cannot occur, because states are exclusive.
- Address wrap: addresses are used as given; no internal increment. Bit 0 picks the byte lane inside the NVRAM wrapper.
- ioctl_ram falling mid-transaction: the transaction completes; any pending ioctl strobe is discarded.
- Reset mid-transaction: the machine returns to IDLE immediately and no write is issued after reset assertion.

Test Plan:
- Reset: hold rst_n=0, pulse CPU and ioctl inputs -> all outputs 0, nv_we never 1.
- CPU write then read: write 0x5A at addr 0x003, then read 0x003 with a 1-cycle-latency memory model.
  - Write: cpu_ok 2 clk after acceptance, nv_we high exactly 1 clk, dirty=1.
  - Read: cpu_dout=0x5A with cpu_ok 3 clk after acceptance.
- Load: ioctl_ram=1, ioctl_wr with addr 0x010 and data 0xA5 -> one nv_we pulse at nv_addr=0x010, nv_data=0xA5, dirty=0.
- Dump: ioctl_rd at each address 0..LAST with AW=2 (LAST=7), memory preloaded with 0x10..0x17.
  - Each read gives ioctl_din_ok with the matching byte 3 clk later.
  - dirty clears after address 7 only.
- Contention: CPU read in flight, raise ioctl_ram and pulse ioctl_wr in the same clock.
  - CPU read completes first.
  - The ioctl write is served from the pending register next.
  - A further cpu_cs gets no cpu_ok until ioctl_ram=0, then completes.
- Async reset during WR: assert rst_n=0 mid-WR -> nv_we drops the same instant, state=IDLE, and no write occurs after release.
